data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised MIPS data memory with a valid/ready request port, configurable response latency,
//  byte/half/word access with byte enables, load sign/zero extension and an address window check.
//  Sits between the CPU MEM stage and word-organised SRAM. Replaces the fixed 1K-word, always-ready memory.
// PARAMETERS
//  DATA_WIDTH  32        word width in bits; fixed at 32 for MIPS byte-lane math
//  ADDR_WIDTH  32        byte-address width
//  DEPTH_LOG2  10        log2 of words stored (1024 words)
//  BASE_ADDR   32'h100   first mapped byte address (word aligned)
//  LATENCY     1         cycles from accept to resp_valid, must be >= 1
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous reset, active-high
//  req_valid    in   1           request present
//  req_ready    out  1           controller can accept; high only in IDLE
//  req_we       in   1           1 = store, 0 = load
//  req_size     in   2           00 byte, 01 half, 10 word (11 reserved, treated as error)
//  req_unsigned in   1           load zero-extends when 1 (lbu/lhu), sign-extends when 0
//  req_addr     in   ADDR_WIDTH  byte address
//  req_wdata    in   DATA_WIDTH  store data, right-justified (sb uses [7:0], sh uses [15:0])
//  resp_valid   out  1           one-cycle pulse: response for the accepted request
//  resp_rdata   out  DATA_WIDTH  extended load data; 0 for stores and errors
//  resp_err     out  1           out-of-window, reserved size, or misaligned (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, counter=0. RAM contents are not reset.
//  FSM states: IDLE -> (req_valid) WAIT -> (counter==LATENCY-1) RESP -> IDLE. With LATENCY=1, WAIT is skipped: IDLE->RESP.
//  Accept = req_valid & req_ready at a rising edge. All request fields are registered at accept.
//  The RAM write is committed on the accept edge. The RAM read is issued on the accept edge.
//  resp_valid is high exactly LATENCY cycles after accept, for 1 cycle. There is no response backpressure.
//  req_ready drops the cycle after accept and rises again in the cycle after RESP. Throughput is 1 request per LATENCY+1 cycles.
//  Window: offset = req_addr - BASE_ADDR. In range iff req_addr >= BASE_ADDR and offset < 4<<DEPTH_LOG2.
//   Word index = offset[DEPTH_LOG2+1:2]. Out of range: no write, rdata=0, err=1.
//  Byte lanes are little-endian; lane = offset[1:0].
//   sb: be=1<<lane, data replicated to all 4 bytes.
//   sh: be=4'b0011<<lane, data replicated to both halves.
//   sw: be=4'b1111.
//  Load: select the byte/half at the lane, then sign- or zero-extend to 32 bits. Word loads ignore req_unsigned.
//  Offset arithmetic is modulo 2^ADDR_WIDTH. The below-base compare is done before subtraction, so no wrap into the window.
//  Reset mid-operation: FSM returns to IDLE and the pending response is dropped. A write accepted before reset stays committed.
//  req_valid held while req_ready=0 is ignored until ready. Requests are not queued.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined:
//   half with addr[0]!=0, or word with addr[1:0]!=0, gives resp_err=1, no write, rdata=0.
//  DMEM_MISALIGN_TRAP_EN undefined:
//   low address bits are forced to alignment (half clears bit0, word clears [1:0]) and the access proceeds with err=0.
// STRUCTURE
//  Package mips_mem_pkg holds:
//   SIZE_BYTE/SIZE_HALF/SIZE_WORD 2-bit constants
//   state typedef/localparams IDLE/WAIT/RESP
//   function be_from(size, lane)
//   function load_extend(word, size, lane, unsigned)
//  Sub-module dmem_ram: synchronous single-port RAM, 2^DEPTH_LOG2 x 32, 4 byte enables, registered read port.
//   Holds the init hook for preloaded words.
//  The top level holds the FSM, latency counter, window check, lane steering and response registers.
// TESTING
//  1 Reset mid-WAIT (LATENCY=4): accept a load, assert rst at cycle 2 -> no resp_valid. After release, req_ready=1 and all outputs are 0.
//  2 LATENCY=1: sw 0xDEADBEEF @0x100, then lw @0x100 -> resp_valid 1 cycle after each accept; rdata=0xDEADBEEF; err=0.
//  3 sb 0x80 @0x102 over 0xDEADBEEF, then lb @0x102 -> rdata=0xFFFFFF80; lbu -> 0x00000080; lw -> 0xDE80BEEF.
//  4 Window: lw @0xFC and @0x100+4096 -> err=1, rdata=0. A following sw to the same address leaves RAM unchanged (readback check).
//  5 LATENCY=3, back-to-back valid: req_ready low for 3 cycles after accept. resp_valid exactly 3 cycles after accept. Second request accepted only once ready.
//  6 lh @0x101: with DMEM_MISALIGN_TRAP_EN -> err=1. Without -> reads the half at 0x100, err=0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants, FSM state type and byte-lane helpers for the MIPS data memory controller.
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // IDLE: ready for a request | WAIT: latency countdown | RESP: last cycle before the response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = 4'b0011 << lane;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        logic [7:0]  byte_val;
        logic [15:0] half_val;
        logic [31:0] result;
        shifted  = word >> {lane, 3'b000};
        byte_val = shifted[7:0];
        half_val = shifted[15:0];
        case (size)
            SIZE_BYTE: result = uns ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
            SIZE_HALF: result = uns ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
            default:   result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the CPU MEM stage (master) and the data memory controller (slave).
interface data_memory_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_ram.sv
// Synchronous single-port word RAM with byte enables and a registered read port.
// The init port lets a loader preload whole words; normal writes take priority over it.
module dmem_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    input  logic                  init_we,
    input  logic [DEPTH_LOG2-1:0] init_idx,
    input  logic [31:0]           init_wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end else if (init_we) begin
            mem[init_idx] <= init_wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/data_memory_ctrl.sv
// MIPS data memory controller: valid/ready request port, LATENCY-cycle response, byte/half/word lanes,
// load extension and address window check. Define DMEM_MISALIGN_TRAP_EN to trap misaligned half/word.
module data_memory_ctrl
    import mips_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h100,
    parameter int                    LATENCY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(64'd4 << DEPTH_LOG2);
    localparam int                    CW        = $clog2(LATENCY + 1);
    localparam logic [CW-1:0]         TC        = CW'(LATENCY - 1);

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  ready_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic                  resp_err_q;

    logic [1:0]            size_q;
    logic                  uns_q;
    logic [1:0]            lane_q;
    logic                  err_q;
    logic                  we_q;

    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;
    logic                  size_bad;
    logic                  req_err;
    logic [1:0]            lane;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]            be;
    logic [31:0]           wdata_lanes;
    logic                  accept;
    logic                  ram_we;
    logic                  ram_re;
    logic [31:0]           ram_rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic                  misaligned;
`endif

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    always_comb begin
        // Below-base is rejected before the subtraction can wrap the offset into the window.
        offset   = bus.req_addr - BASE_ADDR;
        in_range = (bus.req_addr >= BASE_ADDR) && (offset < WIN_BYTES);
        size_bad = (bus.req_size == SIZE_RSVD);
        lane     = offset[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = ((bus.req_size == SIZE_HALF) && offset[0]) ||
                     ((bus.req_size == SIZE_WORD) && (offset[1:0] != 2'b00));
        req_err    = !in_range || size_bad || misaligned;
`else
        req_err = !in_range || size_bad;
        if (bus.req_size == SIZE_HALF) begin
            lane[0] = 1'b0;
        end else if (bus.req_size == SIZE_WORD) begin
            lane = 2'b00;
        end
`endif
        word_idx = offset[DEPTH_LOG2+1:2];
        be       = be_from(bus.req_size, lane);
        case (bus.req_size)
            SIZE_BYTE: wdata_lanes = {4{bus.req_wdata[7:0]}};
            SIZE_HALF: wdata_lanes = {2{bus.req_wdata[15:0]}};
            default:   wdata_lanes = bus.req_wdata[31:0];
        endcase
        accept = bus.req_valid && ready_q;
        ram_we = accept && bus.req_we && !req_err;
        ram_re = accept && !bus.req_we && !req_err;
    end

    dmem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .we        (ram_we),
        .re        (ram_re),
        .be        (be),
        .idx       (word_idx),
        .wdata     (wdata_lanes),
        .init_we   (1'b0),
        .init_idx  ('0),
        .init_wdata(32'b0),
        .rdata     (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        size_q  <= bus.req_size;
                        uns_q   <= bus.req_unsigned;
                        lane_q  <= lane;
                        err_q   <= req_err;
                        we_q    <= bus.req_we;
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == TC) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    ready_q      <= 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= (err_q || we_q) ? '0
                                  : DATA_WIDTH'(load_extend(ram_rdata, size_q, lane_q, uns_q));
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl using three instances (LATENCY 1, 3 and 4) on one clock/reset.
module tb_data_memory_ctrl;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    data_memory_ctrl_if if1 ();
    data_memory_ctrl_if if3 ();
    data_memory_ctrl_if if4 ();

    data_memory_ctrl #(.LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    data_memory_ctrl #(.LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    data_memory_ctrl #(.LATENCY(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int w, input logic v, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] d);
        case (w)
            1: begin
                if1.req_valid = v; if1.req_we = we; if1.req_size = sz;
                if1.req_unsigned = uns; if1.req_addr = a; if1.req_wdata = d;
            end
            3: begin
                if3.req_valid = v; if3.req_we = we; if3.req_size = sz;
                if3.req_unsigned = uns; if3.req_addr = a; if3.req_wdata = d;
            end
            default: begin
                if4.req_valid = v; if4.req_we = we; if4.req_size = sz;
                if4.req_unsigned = uns; if4.req_addr = a; if4.req_wdata = d;
            end
        endcase
    endtask

    function automatic logic get_rv(input int w);
        case (w)
            1:       return if1.resp_valid;
            3:       return if3.resp_valid;
            default: return if4.resp_valid;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int w);
        case (w)
            1:       return if1.resp_rdata;
            3:       return if3.resp_rdata;
            default: return if4.resp_rdata;
        endcase
    endfunction

    function automatic logic get_err(input int w);
        case (w)
            1:       return if1.resp_err;
            3:       return if3.resp_err;
            default: return if4.resp_err;
        endcase
    endfunction

    // One request, then checks response latency, read data and error flag.
    task automatic req_chk(input int w, input int lat, input string tag, input logic we,
                           input logic [1:0] sz, input logic uns, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        @(negedge clk);
        set_req(w, 1'b1, we, sz, uns, a, d);
        @(posedge clk);
        #1;
        set_req(w, 1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (get_rv(w)) begin
                n = i;
                break;
            end
        end
        check({tag, ".lat"}, 32'(n), 32'(lat));
        check({tag, ".rdata"}, get_rdata(w), exp_rd);
        check({tag, ".err"}, {31'b0, get_err(w)}, {31'b0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        logic [7:0] rdy_vec;
        logic [7:0] rv_vec;

        set_req(1, 1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0);
        set_req(3, 1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0);
        set_req(4, 1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.ready", {31'b0, if1.req_ready}, 32'd1);
        check("rst.rvalid", {31'b0, if1.resp_valid}, 32'd0);
        check("rst.rdata", if1.resp_rdata, 32'h0);
        check("rst.err", {31'b0, if1.resp_err}, 32'd0);

        // Reset in the middle of a LATENCY=4 load drops the response
        @(negedge clk);
        set_req(4, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);
        @(posedge clk);
        #1;
        set_req(4, 1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0);
        check("t1.ready_drop", {31'b0, if4.req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t1.ready_in_rst", {31'b0, if4.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (if4.resp_valid) cnt++;
        end
        check("t1.no_resp", 32'(cnt), 32'd0);
        check("t1.ready", {31'b0, if4.req_ready}, 32'd1);
        check("t1.rdata", if4.resp_rdata, 32'h0);
        check("t1.err", {31'b0, if4.resp_err}, 32'd0);
        req_chk(4, 4, "t1.sw", 1'b1, SIZE_WORD, 1'b0, 32'h200, 32'hA5A5A5A5, 32'h0, 1'b0);
        req_chk(4, 4, "t1.lw", 1'b0, SIZE_WORD, 1'b0, 32'h200, 32'h0, 32'hA5A5A5A5, 1'b0);

        // LATENCY=1 word store/load
        req_chk(1, 1, "t2.sw", 1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
        req_chk(1, 1, "t2.lw", 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store and sign/zero extended byte loads
        req_chk(1, 1, "t3.sb", 1'b1, SIZE_BYTE, 1'b0, 32'h102, 32'h00000080, 32'h0, 1'b0);
        req_chk(1, 1, "t3.lb", 1'b0, SIZE_BYTE, 1'b0, 32'h102, 32'h0, 32'hFFFFFF80, 1'b0);
        req_chk(1, 1, "t3.lbu", 1'b0, SIZE_BYTE, 1'b1, 32'h102, 32'h0, 32'h00000080, 1'b0);
        req_chk(1, 1, "t3.lw", 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDE80BEEF, 1'b0);
        req_chk(1, 1, "t3.lhu", 1'b0, SIZE_HALF, 1'b1, 32'h102, 32'h0, 32'h0000DE80, 1'b0);
        req_chk(1, 1, "t3.lb0", 1'b0, SIZE_BYTE, 1'b0, 32'h100, 32'h0, 32'hFFFFFFEF, 1'b0);

        // Address window: last word in range, below base and one past the end rejected
        req_chk(1, 1, "t4.sw_last", 1'b1, SIZE_WORD, 1'b0, 32'h10FC, 32'h11111111, 32'h0, 1'b0);
        req_chk(1, 1, "t4.lw_below", 1'b0, SIZE_WORD, 1'b0, 32'hFC, 32'h0, 32'h0, 1'b1);
        req_chk(1, 1, "t4.lw_above", 1'b0, SIZE_WORD, 1'b0, 32'h1100, 32'h0, 32'h0, 1'b1);
        req_chk(1, 1, "t4.sw_below", 1'b1, SIZE_WORD, 1'b0, 32'hFC, 32'h22222222, 32'h0, 1'b1);
        req_chk(1, 1, "t4.rb_last", 1'b0, SIZE_WORD, 1'b0, 32'h10FC, 32'h0, 32'h11111111, 1'b0);
        req_chk(1, 1, "t4.sw_above", 1'b1, SIZE_WORD, 1'b0, 32'h1100, 32'h33333333, 32'h0, 1'b1);
        req_chk(1, 1, "t4.rb_first", 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hDE80BEEF, 1'b0);
        req_chk(1, 1, "t4.rsvd", 1'b0, SIZE_RSVD, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);

        // LATENCY=3 with valid held high across two requests
        req_chk(3, 3, "t5.sw", 1'b1, SIZE_WORD, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0, 1'b0);
        @(negedge clk);
        set_req(3, 1'b1, 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0);
        rdy_vec = '0;
        rv_vec  = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            rdy_vec[i] = if3.req_ready;
            rv_vec[i]  = if3.resp_valid;
            if (i == 3) check("t5.rdata1", if3.resp_rdata, 32'hCAFEF00D);
            if (i == 4) set_req(3, 1'b0, 1'b0, SIZE_BYTE, 1'b0, 32'h0, 32'h0);
            if (i == 7) check("t5.rdata2", if3.resp_rdata, 32'hCAFEF00D);
        end
        check("t5.ready_pattern", {24'b0, rdy_vec}, 32'h88);
        check("t5.rvalid_pattern", {24'b0, rv_vec}, 32'h88);

        // Misaligned half/word accesses
        req_chk(1, 1, "t6.sh", 1'b1, SIZE_HALF, 1'b0, 32'h102, 32'h00001234, 32'h0, 1'b0);
        req_chk(1, 1, "t6.lh_al", 1'b0, SIZE_HALF, 1'b0, 32'h102, 32'h0, 32'h00001234, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        req_chk(1, 1, "t6.lh_mis", 1'b0, SIZE_HALF, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1);
        req_chk(1, 1, "t6.lw_mis", 1'b0, SIZE_WORD, 1'b0, 32'h103, 32'h0, 32'h0, 1'b1);
        req_chk(1, 1, "t6.sw_mis", 1'b1, SIZE_WORD, 1'b0, 32'h101, 32'h99999999, 32'h0, 1'b1);
        req_chk(1, 1, "t6.rb", 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'h1234BEEF, 1'b0);
`else
        req_chk(1, 1, "t6.lh_mis", 1'b0, SIZE_HALF, 1'b0, 32'h101, 32'h0, 32'hFFFFBEEF, 1'b0);
        req_chk(1, 1, "t6.lw_mis", 1'b0, SIZE_WORD, 1'b0, 32'h103, 32'h0, 32'h1234BEEF, 1'b0);
        req_chk(1, 1, "t6.sh_mis", 1'b1, SIZE_HALF, 1'b0, 32'h103, 32'h0000ABCD, 32'h0, 1'b0);
        req_chk(1, 1, "t6.rb", 1'b0, SIZE_WORD, 1'b0, 32'h100, 32'h0, 32'hABCDBEEF, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
